// File: rtl/axi4_stream_pkt_arbiter.sv
// axi4_stream_pkt_arbiter: packet-level round-robin merge of REQ_AMOUNT
// AXI4-Stream inputs into one output. A grant covers a whole packet
// (through the tlast handshake), followed by one IDLE arbitration cycle.
// Streams are flattened into packed per-input arrays (pkt_i_*) and pkt_o_*.
// Optional feature macro: ARB_PKT_STATS_EN adds per-input 16-bit packet
// counters on pkt_cnt_o.

// Per-input slice: ready gating and, optionally, the packet counter.
module axi4_stream_pkt_arbiter_lane (
  input  logic        sel_i,
  input  logic        tready_i,
  output logic        tready_o
`ifdef ARB_PKT_STATS_EN
  ,
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        last_hs_i,
  output logic [15:0] cnt_o
`endif
);
  assign tready_o = sel_i & tready_i;

`ifdef ARB_PKT_STATS_EN
  // count packets completed from this input; wraps at 16 bits
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                cnt_o <= '0;
    else if (sel_i && last_hs_i) cnt_o <= cnt_o + 16'd1;
  end
`endif
endmodule

module axi4_stream_pkt_arbiter #(
  parameter int REQ_AMOUNT    = 4,
  parameter int TDATA_WIDTH   = 32,
  parameter int TUSER_WIDTH   = 1,
  parameter int TDEST_WIDTH   = 1,
  parameter int TID_WIDTH     = 1,
  parameter int TID_FROM_PORT = 0,
  parameter int REQ_WIDTH     = $clog2(REQ_AMOUNT),
  localparam int KEEP_W       = TDATA_WIDTH / 8
) (
  input  logic                                    clk_i,
  input  logic                                    rst_n_i,
  // input streams
  input  logic [REQ_AMOUNT-1:0]                   pkt_i_tvalid,
  output logic [REQ_AMOUNT-1:0]                   pkt_i_tready,
  input  logic [REQ_AMOUNT-1:0][TDATA_WIDTH-1:0]  pkt_i_tdata,
  input  logic [REQ_AMOUNT-1:0][KEEP_W-1:0]       pkt_i_tstrb,
  input  logic [REQ_AMOUNT-1:0][KEEP_W-1:0]       pkt_i_tkeep,
  input  logic [REQ_AMOUNT-1:0]                   pkt_i_tlast,
  input  logic [REQ_AMOUNT-1:0][TUSER_WIDTH-1:0]  pkt_i_tuser,
  input  logic [REQ_AMOUNT-1:0][TDEST_WIDTH-1:0]  pkt_i_tdest,
  input  logic [REQ_AMOUNT-1:0][TID_WIDTH-1:0]    pkt_i_tid,
  // merged output stream
  output logic                                    pkt_o_tvalid,
  input  logic                                    pkt_o_tready,
  output logic [TDATA_WIDTH-1:0]                  pkt_o_tdata,
  output logic [KEEP_W-1:0]                       pkt_o_tstrb,
  output logic [KEEP_W-1:0]                       pkt_o_tkeep,
  output logic                                    pkt_o_tlast,
  output logic [TUSER_WIDTH-1:0]                  pkt_o_tuser,
  output logic [TDEST_WIDTH-1:0]                  pkt_o_tdest,
  output logic [TID_WIDTH-1:0]                    pkt_o_tid,
  // status
  output logic [REQ_AMOUNT-1:0]                   grant_o,
  output logic [REQ_WIDTH-1:0]                    grant_idx_o,
  output logic                                    busy_o
`ifdef ARB_PKT_STATS_EN
  ,
  output logic [REQ_AMOUNT-1:0][15:0]             pkt_cnt_o
`endif
);
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  logic                 state_q;
  logic [REQ_WIDTH-1:0] grant_idx_q;
  logic [REQ_WIDTH-1:0] next_idx;
  logic                 found;
  logic                 last_hs;

  // round-robin pick: first requesting input after the pointer, wrapping
  always_comb begin
    int                   cand;
    logic [REQ_WIDTH-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    next_idx = grant_idx_q;
    found    = 1'b0;
    for (int i = 1; i <= REQ_AMOUNT; i++) begin
      cand = int'(grant_idx_q) + i;
      if (cand >= REQ_AMOUNT) cand = cand - REQ_AMOUNT;
      cand_idx = REQ_WIDTH'(cand);
      if (!found && pkt_i_tvalid[cand_idx]) begin
        found    = 1'b1;
        next_idx = cand_idx;
      end
    end
  end

  // IDLE latches the winner; GRANT holds it until the tlast handshake.
  // The pointer keeps the last winner so the next scan starts after it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      grant_idx_q <= REQ_WIDTH'(REQ_AMOUNT - 1);
    end else begin
      case (state_q)
        ST_IDLE: if (found) begin
          state_q     <= ST_GRANT;
          grant_idx_q <= next_idx;
        end
        default: if (last_hs) state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q == ST_GRANT);
  assign grant_idx_o = grant_idx_q;

  // output valid depends only on registered grant and the source valid
  assign pkt_o_tvalid = busy_o & pkt_i_tvalid[grant_idx_q];
  assign pkt_o_tdata  = pkt_i_tdata[grant_idx_q];
  assign pkt_o_tstrb  = pkt_i_tstrb[grant_idx_q];
  assign pkt_o_tkeep  = pkt_i_tkeep[grant_idx_q];
  assign pkt_o_tlast  = pkt_i_tlast[grant_idx_q];
  assign pkt_o_tuser  = pkt_i_tuser[grant_idx_q];
  assign pkt_o_tdest  = pkt_i_tdest[grant_idx_q];

  // tid either passes through or is replaced by the source index
  always_comb begin
    pkt_o_tid = pkt_i_tid[grant_idx_q];
    if (TID_FROM_PORT != 0) pkt_o_tid = TID_WIDTH'(grant_idx_q);
  end

  assign last_hs = pkt_o_tvalid & pkt_o_tready & pkt_o_tlast;

  // one-hot decode of the held grant, zero while idle
  always_comb begin
    grant_o = '0;
    if (busy_o) grant_o[grant_idx_q] = 1'b1;
  end

  for (genvar k = 0; k < REQ_AMOUNT; k++) begin : g_lane
    axi4_stream_pkt_arbiter_lane u_lane (
      .sel_i    (grant_o[k]),
      .tready_i (pkt_o_tready),
      .tready_o (pkt_i_tready[k])
`ifdef ARB_PKT_STATS_EN
      ,
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .last_hs_i(last_hs),
      .cnt_o    (pkt_cnt_o[k])
`endif
    );
  end
endmodule

// File: tb/tb_axi4_stream_pkt_arbiter.sv
// Scoreboard bench for axi4_stream_pkt_arbiter (4 inputs, tid from port).
// Packets are pushed in their expected arbitration order, so the expected
// output queue is built as stimulus is issued; the negedge monitor pops it.
module tb_axi4_stream_pkt_arbiter;
  localparam int N = 4;

  typedef struct { logic [31:0] data; logic last; int gap; } word_t;
  typedef struct { logic [31:0] data; logic last; int src; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]       s_tvalid, s_tready, s_tlast;
  logic [N-1:0][31:0] s_tdata;
  logic [N-1:0][3:0]  s_tstrb, s_tkeep;
  logic [N-1:0][0:0]  s_tuser, s_tdest;
  logic [N-1:0][1:0]  s_tid;
  logic        o_tvalid, o_tlast, sink_rdy;
  logic [31:0] o_tdata;
  logic [3:0]  o_tstrb, o_tkeep;
  logic [0:0]  o_tuser, o_tdest;
  logic [1:0]  o_tid;
  logic [N-1:0] grant_o;
  logic [1:0]   grant_idx_o;
  logic         busy_o;
`ifdef ARB_PKT_STATS_EN
  logic [N-1:0][15:0] pkt_cnt_o;
`endif

  axi4_stream_pkt_arbiter #(
    .REQ_AMOUNT(N), .TDATA_WIDTH(32), .TUSER_WIDTH(1), .TDEST_WIDTH(1),
    .TID_WIDTH(2), .TID_FROM_PORT(1)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .pkt_i_tvalid(s_tvalid), .pkt_i_tready(s_tready), .pkt_i_tdata(s_tdata),
    .pkt_i_tstrb(s_tstrb), .pkt_i_tkeep(s_tkeep), .pkt_i_tlast(s_tlast),
    .pkt_i_tuser(s_tuser), .pkt_i_tdest(s_tdest), .pkt_i_tid(s_tid),
    .pkt_o_tvalid(o_tvalid), .pkt_o_tready(sink_rdy), .pkt_o_tdata(o_tdata),
    .pkt_o_tstrb(o_tstrb), .pkt_o_tkeep(o_tkeep), .pkt_o_tlast(o_tlast),
    .pkt_o_tuser(o_tuser), .pkt_o_tdest(o_tdest), .pkt_o_tid(o_tid),
    .grant_o(grant_o), .grant_idx_o(grant_idx_o), .busy_o(busy_o)
`ifdef ARB_PKT_STATS_EN
    , .pkt_cnt_o(pkt_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  word_t    src_q[N][$];
  exp_t     exp_q[$];
  int       beat_cyc[$];
  logic [N-1:0] src_hs;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beats = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // present the head of each source queue, respecting pre-word gaps
  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0 && src_q[k][0].gap == 0) begin
        s_tvalid[k] = 1'b1;
        s_tdata[k]  = src_q[k][0].data;
        s_tlast[k]  = src_q[k][0].last;
        s_tstrb[k]  = src_q[k][0].data[3:0];
      end else begin
        s_tvalid[k] = 1'b0;
        s_tdata[k]  = '0;
        s_tlast[k]  = 1'b0;
        s_tstrb[k]  = '0;
      end
    end
  endtask

  // data word = {src, packet id, word index}; gap idle cycles before word gap_w
  task automatic send_pkt(input int src, input int pid, input int nw,
                          input int gap_w, input int gap_len);
    word_t w;
    exp_t  e;
    for (int i = 0; i < nw; i++) begin
      w.data = {8'(src), 8'(pid), 16'(i)};
      w.last = (i == nw - 1);
      w.gap  = (i == gap_w) ? gap_len : 0;
      src_q[src].push_back(w);
      e.data = w.data; e.last = w.last; e.src = src;
      exp_q.push_back(e);
    end
    drive();
  endtask

  task automatic clear_all();
    for (int k = 0; k < N; k++) src_q[k].delete();
    exp_q.delete();
    beat_cyc.delete();
    src_hs = '0;
    beats  = 0;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sink_rdy = 1'b1;
    clear_all();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  // source side: retire words that handshook on this edge, count down gaps
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N; k++) begin
      if (src_hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      else if (src_q[k].size() > 0 && src_q[k][0].gap > 0)
        src_q[k][0].gap = src_q[k][0].gap - 1;
    end
    src_hs = '0;
    drive();
  end

  // monitor: every output beat must match the head of the expected queue
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      src_hs = s_tvalid & s_tready;
      if (o_tvalid && sink_rdy) begin
        beats++;
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {32'd0, o_tdata}, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {19'd0, o_tdata, o_tid, o_tlast, o_tuser, o_tdest, o_tstrb, o_tkeep},
              {19'd0, e.data, 2'(e.src), e.last, e.src[0], e.src[1], e.data[3:0], 4'hF});
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    int n, stall;
    for (int k = 0; k < N; k++) begin
      s_tkeep[k] = 4'hF;
      s_tuser[k] = 1'(k);
      s_tdest[k] = 1'(k >> 1);
      s_tid[k]   = 2'd0;
    end
    s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_tstrb = '0;
    src_hs = '0;

    // 1: reset state, then a lone 3-word packet on input 2
    do_reset();
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_idx", 64'(grant_idx_o), 64'd3);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_tvalid", 64'(o_tvalid), 64'd0);
    chk("rst_tready", 64'(s_tready), 64'd0);
    send_pkt(2, 0, 3, -1, 0);
    @(negedge clk); #1;
    chk("t1_latency_grant", 64'(grant_o), 64'd0);
    @(negedge clk); #1;
    chk("t1_grant", 64'(grant_o), 64'b0100);
    chk("t1_tvalid", 64'(o_tvalid), 64'd1);
    drain("t1", 20);
    chk("t1_nbeats", 64'(beat_cyc.size()), 64'd3);
    if (beat_cyc.size() == 3) chk("t1_consecutive", 64'(beat_cyc[2] - beat_cyc[0]), 64'd2);
    @(negedge clk); #1;
    chk("t1_busy_drop", 64'(busy_o), 64'd0);
    chk("t1_grant_drop", 64'(grant_o), 64'd0);

    // 2: all inputs hold two 2-word packets; expected order 0,1,2,3,0,1,2,3
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < N; k++) send_pkt(k, p, 2, -1, 0);
    drain("t2", 60);
    chk("t2_nbeats", 64'(beats), 64'd16);
    if (beat_cyc.size() == 16) chk("t2_span", 64'(beat_cyc[15] - beat_cyc[0]), 64'd22);
    @(negedge clk); #1;
    chk("t2_busy_drop", 64'(busy_o), 64'd0);
`ifdef ARB_PKT_STATS_EN
    for (int k = 0; k < N; k++) chk("t2_pkt_cnt", 64'(pkt_cnt_o[k]), 64'd2);
`endif

    // 3: input 1 granted, sink ready toggles; 3 then 0 queue up meanwhile
    do_reset();
    send_pkt(1, 0, 4, -1, 0);
    @(negedge clk); @(negedge clk); #1;
    chk("t3_grant", 64'(grant_o), 64'b0010);
    @(posedge clk); #2;
    send_pkt(3, 0, 1, -1, 0);
    send_pkt(0, 0, 1, -1, 0);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(posedge clk); #2;
      sink_rdy = ~i[0];
      @(negedge clk); #1;
      if (busy_o && grant_idx_o == 2'd1) begin
        chk("t3_rdy0", 64'(s_tready[0]), 64'd0);
        chk("t3_rdy3", 64'(s_tready[3]), 64'd0);
        chk("t3_rdy1", 64'(s_tready[1]), 64'(sink_rdy));
      end
    end
    @(posedge clk); #2;
    sink_rdy = 1'b1;
    drain("t3", 20);

    // 4: input 0 stalls 5 cycles mid-packet while input 3 waits
    do_reset();
    send_pkt(0, 0, 4, 2, 5);
    send_pkt(3, 0, 1, -1, 0);
    n = 0; stall = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk); #1;
      n++;
      if (busy_o && grant_idx_o == 2'd0) begin
        chk("t4_rdy3", 64'(s_tready[3]), 64'd0);
        if (!o_tvalid) stall++;
      end
    end
    chk("t4_drained", 64'(exp_q.size()), 64'd0);
    chk("t4_stall_cycles", 64'(stall), 64'd5);
    chk("t4_last_winner", 64'(grant_idx_o), 64'd3);

    // 5: packet from input 3 with source tid 0 carries tid 3 on every word
    do_reset();
    send_pkt(3, 5, 3, -1, 0);
    drain("t5", 20);
    chk("t5_nbeats", 64'(beats), 64'd3);

    // 6: asynchronous reset mid-packet, then input 0 wins first
    do_reset();
    send_pkt(0, 6, 4, -1, 0);
    n = 0;
    while (beats < 2 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("t6_started", 64'(beats), 64'd2);
    @(posedge clk); #3;
    rst_n = 1'b0;
    clear_all();
    #1;
    chk("t6_grant", 64'(grant_o), 64'd0);
    chk("t6_busy", 64'(busy_o), 64'd0);
    chk("t6_tready", 64'(s_tready), 64'd0);
    chk("t6_tvalid", 64'(o_tvalid), 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
`ifdef ARB_PKT_STATS_EN
    for (int k = 0; k < N; k++) chk("t6_pkt_cnt", 64'(pkt_cnt_o[k]), 64'd0);
`endif
    @(posedge clk); #2;
    for (int k = 0; k < N; k++) send_pkt(k, 7, 1, -1, 0);
    @(negedge clk); @(negedge clk); #1;
    chk("t6_first_winner", 64'(grant_o), 64'b0001);
    drain("t6", 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
